// File: rtl/burst_pkg.sv
// burst_pkg
// Shared types and defaults for the burst request generator slice.
//   addr_t         : 64-bit byte address
//   len_t          : 32-bit word count
//   burst_state_e  : control FSM states (IDLE, ISSUE, DRAIN, DONE)
//   BURST_MAX_DEFAULT / WORD_BYTES_DEFAULT : default parameter values
package burst_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [31:0] len_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } burst_state_e;

  localparam int BURST_MAX_DEFAULT  = 10;
  localparam int WORD_BYTES_DEFAULT = 8;

endpackage

// File: rtl/burst_len_calc.sv
// burst_len_calc
// Purely combinational burst length for a given start address and the
// number of words still to request:
//   len = min(remaining, MAX_BURST, words left before the next boundary)
// Ports:
//   cur_addr  : in  64 - byte address of the next burst
//   remaining : in  32 - words not yet requested
//   len       : out 32 - words for the next burst (0 only when remaining is 0)
module burst_len_calc
  import burst_pkg::*;
#(
  parameter int MAX_BURST      = BURST_MAX_DEFAULT,
  parameter int WORD_BYTES     = WORD_BYTES_DEFAULT,
  parameter int BOUNDARY_BYTES = 4096
) (
  input  addr_t cur_addr,
  input  len_t  remaining,
  output len_t  len
);

  localparam addr_t BOUNDARY = addr_t'(BOUNDARY_BYTES);
  localparam addr_t WORD     = addr_t'(WORD_BYTES);
  localparam len_t  MAX_LEN  = len_t'(MAX_BURST);

  addr_t offset;
  addr_t to_boundary;

  // BOUNDARY_BYTES is a power of two, so the modulo is a simple mask.
  always_comb begin
    offset      = cur_addr & (BOUNDARY - 64'd1);
    to_boundary = (BOUNDARY - offset) / WORD;
    len         = remaining;
    if (len > MAX_LEN) begin
      len = MAX_LEN;
    end
    if (to_boundary < addr_t'(len)) begin
      len = len_t'(to_boundary);
    end
  end

endmodule

// File: rtl/burst_req_gen.sv
// burst_req_gen
// Splits one transfer command (base byte address + word count) into burst
// requests capped at MAX_BURST words that never cross a BOUNDARY_BYTES
// boundary, throttled so that no more than MAX_PENDING beats are outstanding.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : command pulse, sampled in IDLE only
//   base_addr         : command byte address (WORD_BYTES aligned)
//   total_words       : command word count (0 legal)
//   busy, done, err   : status; done is a one-cycle pulse, err is sticky
//   req_valid/ready   : request handshake
//   req_addr, req_len : request address and word count (registered)
//   rsp_valid         : one returned data beat
module burst_req_gen
  import burst_pkg::*;
#(
  parameter int MAX_BURST      = BURST_MAX_DEFAULT,
  parameter int WORD_BYTES     = WORD_BYTES_DEFAULT,
  parameter int BOUNDARY_BYTES = 4096,
  parameter int MAX_PENDING    = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] base_addr,
  input  logic [31:0] total_words,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [63:0] req_addr,
  output logic [31:0] req_len,
  input  logic        rsp_valid
);

  burst_state_e state;
  len_t         remaining;
  len_t         pending;

  addr_t nxt_addr;
  len_t  nxt_rem;
  len_t  nxt_len;
  len_t  nxt_pending;
  logic  hs;
  logic  beat;
  logic  stray;
  logic  misaligned;

  // req_addr doubles as the current-address register and req_len holds the
  // length for that address, so the length is computed from next-state
  // values and registered together with the address.
  burst_len_calc #(
    .MAX_BURST      (MAX_BURST),
    .WORD_BYTES     (WORD_BYTES),
    .BOUNDARY_BYTES (BOUNDARY_BYTES)
  ) u_len_calc (
    .cur_addr  (nxt_addr),
    .remaining (nxt_rem),
    .len       (nxt_len)
  );

  // Throttle: only offer a request whose beats fit under the pending cap.
  // Pending only falls while valid is high, so this never retracts.
  assign req_valid = (state == ST_ISSUE) &&
                     ({1'b0, pending} + {1'b0, req_len} <= 33'(MAX_PENDING));

  always_comb begin
    hs         = req_valid & req_ready;
    beat       = rsp_valid && (pending != '0);
    stray      = rsp_valid && ((pending == '0) || (state == ST_IDLE) || (state == ST_DONE));
    misaligned = (base_addr % addr_t'(WORD_BYTES)) != '0;
    nxt_addr   = req_addr;
    nxt_rem    = remaining;
    if (state == ST_IDLE && start) begin
      nxt_addr = base_addr;
      nxt_rem  = total_words;
    end else if (hs) begin
      nxt_addr = req_addr + addr_t'(req_len) * addr_t'(WORD_BYTES);
      nxt_rem  = remaining - req_len;
    end
    nxt_pending = pending + (hs ? req_len : '0) - len_t'(beat);
  end

  // Control FSM. done and busy are registered on the way out of DONE, so the
  // done pulse and busy falling land in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_addr  <= '0;
      req_len   <= '0;
      remaining <= '0;
      pending   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      req_addr  <= nxt_addr;
      remaining <= nxt_rem;
      req_len   <= nxt_len;
      pending   <= nxt_pending;
      done      <= 1'b0;
      if (stray) begin
        err <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            err  <= misaligned | stray;
            if (misaligned || total_words == '0) begin
              state <= ST_DONE;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (hs && nxt_rem == '0) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (nxt_pending == '0) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_req_gen.sv
// tb_burst_req_gen
// Directed bench for burst_req_gen with hand-computed expected requests,
// timing and status values. Inputs change and outputs are sampled 1 ns
// after the rising edge; handshakes and beats are recorded at the falling edge.
module tb_burst_req_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] base_addr;
  logic [31:0] total_words;
  logic        busy;
  logic        done;
  logic        err;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [31:0] req_len;
  logic        rsp_valid;

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] got_addr[$];
  logic [31:0] got_len[$];
  int          pend_m;
  int          beats;
  int          done_cnt;
  int          cyc;
  int          last_beat_cyc;
  int          done_cyc;
  logic        done_busy;

  burst_req_gen dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .total_words (total_words),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .rsp_valid   (rsp_valid)
  );

  always #5 clk = ~clk;

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Records this cycle's events at the falling edge, then moves on to 1 ns
  // after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (req_valid && req_ready) begin
      got_addr.push_back(req_addr);
      got_len.push_back(req_len);
      pend_m += int'(req_len);
    end
    if (rsp_valid) begin
      beats++;
      last_beat_cyc = cyc;
      if (pend_m > 0) pend_m--;
    end
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = busy;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Pulses start for one cycle; returns 1 ns after the edge that samples it.
  task automatic applyStimulus(input logic [63:0] addr, input logic [31:0] words);
    got_addr.delete();
    got_len.delete();
    beats     = 0;
    done_cnt  = 0;
    base_addr = addr;
    total_words = words;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Returns a beat whenever words are outstanding, until done or budget.
  task automatic runUntilDone(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      rsp_valid = (pend_m > 0);
      tick();
    end
    rsp_valid = 1'b0;
  endtask

  task automatic checkRequests(input string tag, input logic [63:0] ea[], input logic [31:0] el[]);
    checkOutput({tag, "_count"}, 64'(got_addr.size()), 64'(ea.size()));
    for (int i = 0; i < ea.size(); i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), (i < got_addr.size()) ? got_addr[i] : '1, ea[i]);
      checkOutput($sformatf("%s_len%0d", tag, i), (i < got_len.size()) ? 64'(got_len[i]) : '1, 64'(el[i]));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; total_words = '0;
    req_ready = 1'b0; rsp_valid = 1'b0;
    pend_m = 0; beats = 0; done_cnt = 0; cyc = 0;
    last_beat_cyc = 0; done_cyc = 0; done_busy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_valid", req_valid, 0);
    checkOutput("rst_addr", req_addr, 0);
    checkOutput("rst_len", req_len, 0);
    rst = 1'b0;
    tick();

    // Normal split: 25 words from 0x1000
    req_ready = 1'b1;
    applyStimulus(64'h1000, 25);
    checkOutput("norm_busy", busy, 1);
    checkOutput("norm_first_valid", req_valid, 1);
    runUntilDone(200);
    checkRequests("norm", '{64'h1000, 64'h1050, 64'h10A0}, '{32'd10, 32'd10, 32'd5});
    checkOutput("norm_beats", beats, 25);
    checkOutput("norm_done_cnt", done_cnt, 1);
    checkOutput("norm_done_lat", done_cyc - last_beat_cyc, 2);
    checkOutput("norm_busy_at_done", done_busy, 0);
    checkOutput("norm_err", err, 0);

    // Zero-length command
    applyStimulus(64'h2000, 0);
    checkOutput("zero_busy1", busy, 1);
    checkOutput("zero_done1", done, 0);
    checkOutput("zero_valid1", req_valid, 0);
    tick();
    checkOutput("zero_done2", done, 1);
    checkOutput("zero_busy2", busy, 0);
    checkOutput("zero_err", err, 0);
    tick();
    checkOutput("zero_done3", done, 0);
    checkOutput("zero_reqs", got_addr.size(), 0);

    // Misaligned command
    applyStimulus(64'h1004, 5);
    checkOutput("mis_done1", done, 0);
    tick();
    checkOutput("mis_done2", done, 1);
    checkOutput("mis_err", err, 1);
    tick();
    checkOutput("mis_err_sticky", err, 1);
    checkOutput("mis_reqs", got_addr.size(), 0);

    // Boundary split: 10 words from 0x0FD8
    applyStimulus(64'h0FD8, 10);
    checkOutput("bnd_err_cleared", err, 0);
    runUntilDone(200);
    checkRequests("bnd", '{64'h0FD8, 64'h1000}, '{32'd5, 32'd5});
    checkOutput("bnd_beats", beats, 10);
    checkOutput("bnd_done_cnt", done_cnt, 1);

    // Backpressure, simultaneous events and throttle: 30 words from 0x1000
    req_ready = 1'b0;
    applyStimulus(64'h1000, 30);
    checkOutput("bp_valid", req_valid, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bp_hold_valid", req_valid, 1);
      checkOutput("bp_hold_addr", req_addr, 64'h1000);
      checkOutput("bp_hold_len", req_len, 10);
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    checkOutput("bp_pend10", dut.pending, 10);
    checkOutput("bp_addr2", req_addr, 64'h1050);
    checkOutput("bp_valid2", req_valid, 1);
    rsp_valid = 1'b1;
    repeat (5) tick();
    checkOutput("sim_pend5", dut.pending, 5);
    checkOutput("sim_addr_stable", req_addr, 64'h1050);
    req_ready = 1'b1;
    tick();
    checkOutput("sim_pend14", dut.pending, 14);
    checkOutput("thr_addr3", req_addr, 64'h10A0);
    checkOutput("thr_len3", req_len, 10);
    checkOutput("thr_valid_14", req_valid, 0);
    repeat (3) tick();
    checkOutput("thr_pend11", dut.pending, 11);
    checkOutput("thr_valid_11", req_valid, 0);
    tick();
    checkOutput("thr_pend10", dut.pending, 10);
    checkOutput("thr_valid_10", req_valid, 1);
    rsp_valid = 1'b0;
    tick();
    checkOutput("thr_pend20", dut.pending, 20);
    checkOutput("thr_valid_drain", req_valid, 0);
    runUntilDone(200);
    checkOutput("thr_reqs", got_addr.size(), 3);
    checkOutput("thr_beats", beats, 30);
    checkOutput("thr_done_cnt", done_cnt, 1);
    checkOutput("thr_err", err, 0);

    // Reset mid-ISSUE, then a stray beat in IDLE
    req_ready = 1'b0;
    applyStimulus(64'h1000, 25);
    checkOutput("mid_valid", req_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_err", err, 0);
    checkOutput("mid_rst_valid", req_valid, 0);
    checkOutput("mid_rst_addr", req_addr, 0);
    checkOutput("mid_rst_len", req_len, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pend_m = 0;
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    checkOutput("stray_err", err, 1);
    checkOutput("stray_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/burst_req_gen.md
# burst_req_gen

Upstream request generator for the DPI burst-read stage. It takes one transfer command (base byte address plus total 64-bit word count) and splits it into a sequence of burst requests (address, length). Each request is capped at `MAX_BURST` words and never crosses a `BOUNDARY_BYTES` boundary. It throttles issue against returned data beats and signals completion once every requested word has come back.

## Interface
Parameters:
- `MAX_BURST`, default 10: maximum words per request (≥1).
- `WORD_BYTES`, default 8: bytes per word; address step per word.
- `BOUNDARY_BYTES`, default 4096: power-of-two boundary no burst may cross.
- `MAX_PENDING`, default 20: maximum requested-but-not-returned beats.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: command pulse. Sampled only in IDLE.
- `base_addr`, in, 64: command byte address. Must be `WORD_BYTES`-aligned.
- `total_words`, in, 32: command word count. 0 is legal.
- `busy`, out, 1: high from the cycle after an accepted start until `done`.
- `done`, out, 1: one-cycle completion pulse.
- `err`, out, 1: sticky error flag. Cleared by the next accepted start or by reset.
- `req_valid`, out, 1: request valid.
- `req_ready`, in, 1: downstream accepts the request.
- `req_addr`, out, 64: burst start byte address.
- `req_len`, out, 32: burst word count, 1..`MAX_BURST`.
- `rsp_valid`, in, 1: one returned data word (beat) this cycle.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `start`=1 latches `cur_addr`=`base_addr` and `remaining`=`total_words`, and clears `err`.
  - If `base_addr` is misaligned: set `err` and go to DONE. No requests are issued.
  - Else if `total_words`=0: go to DONE.
  - Else: go to ISSUE.
- Burst length: `len` = min(`remaining`, `MAX_BURST`, `words_to_boundary`), where `words_to_boundary` = (`BOUNDARY_BYTES` − (`cur_addr` mod `BOUNDARY_BYTES`)) / `WORD_BYTES`.
- ISSUE:
  - `req_valid` is high only when `pending` + `len` ≤ `MAX_PENDING`.
  - On handshake (`req_valid` & `req_ready`): `cur_addr` += `len`×`WORD_BYTES`, `remaining` −= `len`, `pending` += `len`.
  - When `remaining` reaches 0: go to DRAIN.
- DRAIN: when `pending`=0, go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `pending` counter (32-bit):
  - Each `rsp_valid` decrements it by 1.
  - On a simultaneous handshake and `rsp_valid`, next `pending` = `pending` + `len` − 1.
- Stray beat: `rsp_valid` with `pending`=0, or in IDLE/DONE, sets `err`. The counter does not underflow.
- Address arithmetic is modulo 2^64; wrap is not flagged.
- `start` outside IDLE is ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `req_valid`=0, `req_addr`=0, `req_len`=0. Internal state is IDLE and all counters are 0.
- `req_addr`, `req_len` and `busy` are registered outputs. `req_valid` may be combinational from state, `pending` and `len`.
- First `req_valid` is asserted 1 cycle after the `start` edge at the earliest.
- Once `req_valid` is high, `req_addr` and `req_len` hold stable and `req_valid` stays high until handshake. No retraction.
- Back-to-back requests are allowed: after a handshake, the next request may be valid on the following cycle.
- `done` comes 1 cycle after `pending` reaches 0 in DRAIN.
- Zero-length or misaligned command: `done` fires 2 cycles after the `start` edge.
- `busy` deasserts in the same cycle `done` is high.
- Reset mid-operation:
  - Returns everything to reset values immediately.
  - In-flight beats that arrive after reset while in IDLE set `err`. The testbench must drain these before reset if that is not wanted.

## Structure
- Package `burst_pkg`:
  - `addr_t` (64-bit) and `len_t` (32-bit).
  - State enum `burst_state_e`.
  - Default constants `BURST_MAX_DEFAULT`=10 and `WORD_BYTES_DEFAULT`=8.
- Sub-module `burst_len_calc`: purely combinational `len` computation from `cur_addr`, `remaining` and the parameters. It is unit-testable on its own.

## Test plan
- Normal split: `base_addr`=0x1000, `total_words`=25, `req_ready` tied 1.
  - Required requests: (0x1000,10), (0x1050,10), (0x10A0,5).
  - Then 25 beats, then `done` once.
- Boundary split: `base_addr`=0x0FD8, `total_words`=10.
  - Required requests: (0x0FD8,5), (0x1000,5).
- Zero length: `total_words`=0.
  - No `req_valid`, `done` at start+2, `err`=0.
  - Misaligned `base_addr`=0x1004: same timing, with `err`=1.
- Backpressure and throttle:
  - Hold `req_ready`=0 for 3 cycles; `req_addr` and `req_len` must stay stable.
  - With `MAX_PENDING`=20 and no beats returned, the third request of a 30-word command stays invalid until ≥10 beats arrive.
- Simultaneous events: a handshake with `len`=10 in the same cycle as `rsp_valid` while `pending`=5 gives `pending`=14.
- Reset and stray beat:
  - Assert `rst` mid-ISSUE: all outputs return to reset values the same cycle.
  - A later `rsp_valid` in IDLE sets `err`=1.
